// File: rtl/gerenciador_bolas.sv
// Allied projectile pool: allocates slots on fire edges, moves
// live projectiles upward every game tick, frees them on hit or exit.
module gerenciador_bolas #(
  parameter int N_BOLAS  = 4,
  parameter int VEL      = 3,
  parameter int TICK_DIV = 500000,
  parameter int COOLDOWN = 8,
  parameter int Y_MIN    = 0,
  parameter int RAIO     = 5
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   pausa,
  input  logic                   disparar,
  input  logic [9:0]             x_origem,
  input  logic [9:0]             y_origem,
  input  logic [N_BOLAS-1:0]     acerto,
  output logic [10*N_BOLAS-1:0]  x_bolas,
  output logic [10*N_BOLAS-1:0]  y_bolas,
  output logic [N_BOLAS-1:0]     ativa,
  output logic [9:0]             raio_bola,
  output logic                   disparo_aceito,
  output logic                   tick
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = $clog2(COOLDOWN + 2);
  localparam logic [9:0] LIMITE = 10'(Y_MIN + VEL);
  localparam logic [9:0] VEL_V  = 10'(VEL);

  typedef enum logic {LIVRE, ATIVA} estado_t;

  estado_t       est_q [N_BOLAS];
  estado_t       est_d [N_BOLAS];
  logic [9:0]    x_q   [N_BOLAS];
  logic [9:0]    x_d   [N_BOLAS];
  logic [9:0]    y_q   [N_BOLAS];
  logic [9:0]    y_d   [N_BOLAS];
  logic [TW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cd_q, cd_d;
  logic          disp_q;

  logic               fire_req;
  logic               livre_any;
  logic [N_BOLAS-1:0] sel;

  always_comb begin
    tick  = ~pausa & (cnt_q == TW'(TICK_DIV - 1));
    cnt_d = cnt_q;
    if (!pausa)
      cnt_d = tick ? '0 : cnt_q + TW'(1);

    fire_req  = disparar & ~disp_q;
    sel       = '0;
    livre_any = 1'b0;
    // A slot hit this cycle is still ATIVA here, so it is not reused yet
    for (int i = 0; i < N_BOLAS; i++) begin
      if (est_q[i] == LIVRE && !livre_any) begin
        sel[i]    = 1'b1;
        livre_any = 1'b1;
      end
    end

    disparo_aceito = fire_req & ~pausa & (cd_q == '0) & livre_any;

    cd_d = cd_q;
    if (disparo_aceito)
      cd_d = CW'(COOLDOWN);
    else if (tick && cd_q != '0)
      cd_d = cd_q - CW'(1);
  end

  always_comb begin
    for (int i = 0; i < N_BOLAS; i++) begin
      est_d[i] = est_q[i];
      x_d[i]   = x_q[i];
      y_d[i]   = y_q[i];
      if (!pausa) begin
        if (est_q[i] == LIVRE) begin
          if (disparo_aceito && sel[i]) begin
            est_d[i] = ATIVA;
            x_d[i]   = x_origem;
            y_d[i]   = y_origem;
          end
        end else if (acerto[i]) begin
          est_d[i] = LIVRE;
        end else if (tick) begin
          // Exit test precedes subtraction so y never wraps
          if (y_q[i] < LIMITE)
            est_d[i] = LIVRE;
          else
            y_d[i] = y_q[i] - VEL_V;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      cd_q   <= '0;
      disp_q <= 1'b0;
      for (int i = 0; i < N_BOLAS; i++) begin
        est_q[i] <= LIVRE;
        x_q[i]   <= '0;
        y_q[i]   <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      cd_q   <= cd_d;
      disp_q <= disparar;
      for (int i = 0; i < N_BOLAS; i++) begin
        est_q[i] <= est_d[i];
        x_q[i]   <= x_d[i];
        y_q[i]   <= y_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_BOLAS; i++) begin
      ativa[i]          = (est_q[i] == ATIVA);
      x_bolas[10*i +: 10] = x_q[i];
      y_bolas[10*i +: 10] = y_q[i];
    end
  end

  assign raio_bola = 10'(RAIO);

endmodule
